// File: rtl/reset_sequencer.sv
// Reset sequencer: merges extRstn/porIn into one request, stretches it, then releases
// N_CH reset channels in order at GAP spacing. Optional watchdog: `define RESET_SEQ_WDOG_EN.
module reset_sequencer #(
  parameter int N_CH        = 4,
  parameter int STRETCH     = 16,
  parameter int GAP         = 4,
  parameter int SYNC_STAGES = 2,
  parameter int WDOG_CYCLES = 1024
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            extRstn,
  input  logic            porIn,
  input  logic            porClear,
  input  logic            wdKick,
  output logic [N_CH-1:0] rst,
  output logic            busy,
  output logic            done,
  output logic            porStatus,
  output logic            wdStatus
);

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) begin
      m = b;
    end else begin
      m = m;
    end
    if (c > m) begin
      m = c;
    end else begin
      m = m;
    end
    return m;
  endfunction

  localparam int CNT_MAX = max3(STRETCH, GAP, WDOG_CYCLES);
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int IDX_W   = $clog2(N_CH) + 1;

  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO     = CNT_W'(0);
  localparam logic [CNT_W-1:0] STRETCH_LAST = CNT_W'(STRETCH - 1);
  localparam logic [CNT_W-1:0] GAP_LAST     = CNT_W'(GAP - 1);
  localparam logic [IDX_W-1:0] IDX_ONE      = IDX_W'(1);
  localparam logic [IDX_W-1:0] IDX_ZERO     = IDX_W'(0);
  localparam logic [IDX_W-1:0] IDX_LAST     = IDX_W'(N_CH - 1);
  localparam logic [N_CH-1:0]  CH_ONE       = N_CH'(1);
  localparam logic [N_CH-1:0]  CH_ALL       = {N_CH{1'b1}};
  localparam logic [N_CH-1:0]  CH_NONE      = {N_CH{1'b0}};

  localparam logic [1:0] ST_ASSERT  = 2'd0;
  localparam logic [1:0] ST_RELEASE = 2'd1;
  localparam logic [1:0] ST_RUN     = 2'd2;

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [1:0]             state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [N_CH-1:0]        rst_q, rst_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   por_status_q, por_status_d;
  logic                   ext_sync;
  logic                   wd_trip;
  logic                   req;

  assign ext_sync = sync_q[SYNC_STAGES-1];
  assign req      = ~ext_sync | porIn | wd_trip;

  // Synchroniser shift and power-on sticky status
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], extRstn};
    if (porIn) begin
      por_status_d = 1'b1;
    end else if (porClear) begin
      por_status_d = 1'b0;
    end else begin
      por_status_d = por_status_q;
    end
  end

  // Sequencer: stretch the request, then walk the release index one channel per GAP
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    rst_d   = rst_q;
    case (state_q)
      ST_ASSERT: begin
        rst_d = CH_ALL;
        if (req) begin
          cnt_d = CNT_ZERO;
        end else if (cnt_q == STRETCH_LAST) begin
          cnt_d = CNT_ZERO;
          idx_d = IDX_ZERO;
          if (N_CH == 1) begin
            state_d = ST_RUN;
            rst_d   = CH_NONE;
          end else begin
            state_d = ST_RELEASE;
            rst_d   = ~CH_ONE;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_RELEASE: begin
        if (req) begin
          state_d = ST_ASSERT;
          cnt_d   = CNT_ZERO;
          idx_d   = IDX_ZERO;
          rst_d   = CH_ALL;
        end else if (cnt_q == GAP_LAST) begin
          cnt_d = CNT_ZERO;
          idx_d = idx_q + IDX_ONE;
          rst_d = rst_q & ~(CH_ONE << (idx_q + IDX_ONE));
          if ((idx_q + IDX_ONE) == IDX_LAST) begin
            state_d = ST_RUN;
          end else begin
            state_d = ST_RELEASE;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_RUN: begin
        if (req) begin
          state_d = ST_ASSERT;
          cnt_d   = CNT_ZERO;
          idx_d   = IDX_ZERO;
          rst_d   = CH_ALL;
        end else begin
          rst_d = CH_NONE;
        end
      end
      default: begin
        state_d = ST_ASSERT;
        cnt_d   = CNT_ZERO;
        idx_d   = IDX_ZERO;
        rst_d   = CH_ALL;
      end
    endcase
    done_d = (state_d == ST_RUN);
    busy_d = (state_d != ST_RUN);
  end

  // State, counters and registered outputs
  always_ff @(posedge clk) begin
    if (!rstn) begin
      sync_q       <= {SYNC_STAGES{1'b0}};
      state_q      <= ST_ASSERT;
      cnt_q        <= CNT_ZERO;
      idx_q        <= IDX_ZERO;
      rst_q        <= CH_ALL;
      busy_q       <= 1'b1;
      done_q       <= 1'b0;
      por_status_q <= 1'b1;
    end else begin
      sync_q       <= sync_d;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      rst_q        <= rst_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      por_status_q <= por_status_d;
    end
  end

  assign rst       = rst_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign porStatus = por_status_q;

`ifdef RESET_SEQ_WDOG_EN
  localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(WDOG_CYCLES - 1);

  logic [CNT_W-1:0] wd_cnt_q, wd_cnt_d;
  logic             wd_status_q, wd_status_d;

  // Watchdog: only live in RUN; a kick on the would-be trip cycle still wins
  always_comb begin
    wd_trip  = 1'b0;
    wd_cnt_d = CNT_ZERO;
    if (state_q != ST_RUN) begin
      wd_cnt_d = CNT_ZERO;
    end else if (wdKick) begin
      wd_cnt_d = CNT_ZERO;
    end else if (wd_cnt_q == WD_LAST) begin
      wd_trip  = 1'b1;
      wd_cnt_d = CNT_ZERO;
    end else begin
      wd_cnt_d = wd_cnt_q + CNT_ONE;
    end
    if (wd_trip) begin
      wd_status_d = 1'b1;
    end else if (porClear) begin
      wd_status_d = 1'b0;
    end else begin
      wd_status_d = wd_status_q;
    end
  end

  // Watchdog counter and sticky timeout status
  always_ff @(posedge clk) begin
    if (!rstn) begin
      wd_cnt_q    <= CNT_ZERO;
      wd_status_q <= 1'b0;
    end else begin
      wd_cnt_q    <= wd_cnt_d;
      wd_status_q <= wd_status_d;
    end
  end

  assign wdStatus = wd_status_q;
`else
  logic wd_kick_unused;

  assign wd_kick_unused = wdKick;
  assign wd_trip        = 1'b0;
  assign wdStatus       = 1'b0;
`endif

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer: default instance, a 1-channel corner instance and
// a short-watchdog instance; watchdog expectations follow RESET_SEQ_WDOG_EN.
module tb_reset_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rstn;
  logic       ext_rstn, por_in, por_clear, wd_kick;
  logic [3:0] rst_o;
  logic       busy_o, done_o, pors_o, wds_o;

  logic       ext_rstn1, por_in1, por_clear1, wd_kick1;
  logic [0:0] rst1;
  logic       busy1, done1, pors1, wds1;

  logic       ext_rstn_w, por_in_w, por_clear_w, wd_kick_w;
  logic [3:0] rst_w;
  logic       busy_w, done_w, pors_w, wds_w;

  int n_checks = 0;
  int n_fail   = 0;

  reset_sequencer dut (
    .clk(clk), .rstn(rstn), .extRstn(ext_rstn), .porIn(por_in), .porClear(por_clear),
    .wdKick(wd_kick), .rst(rst_o), .busy(busy_o), .done(done_o),
    .porStatus(pors_o), .wdStatus(wds_o)
  );

  reset_sequencer #(.N_CH(1), .STRETCH(1), .GAP(1)) dut1 (
    .clk(clk), .rstn(rstn), .extRstn(ext_rstn1), .porIn(por_in1), .porClear(por_clear1),
    .wdKick(wd_kick1), .rst(rst1), .busy(busy1), .done(done1),
    .porStatus(pors1), .wdStatus(wds1)
  );

  reset_sequencer #(.WDOG_CYCLES(8)) dutw (
    .clk(clk), .rstn(rstn), .extRstn(ext_rstn_w), .porIn(por_in_w), .porClear(por_clear_w),
    .wdKick(wd_kick_w), .rst(rst_w), .busy(busy_w), .done(done_w),
    .porStatus(pors_w), .wdStatus(wds_w)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Channel pattern r edges after the first request-free cycle (STRETCH=16, GAP=4)
  function automatic logic [3:0] exp_rst(input int r);
    if (r < 16)      return 4'hF;
    else if (r < 20) return 4'hE;
    else if (r < 24) return 4'hC;
    else if (r < 28) return 4'h8;
    else             return 4'h0;
  endfunction

  task automatic check_release(input string tag, input int n);
    for (int r = 1; r <= n; r++) begin
      step();
      check_eq($sformatf("%s rst r=%0d", tag, r), 32'(rst_o), 32'(exp_rst(r)));
      check_eq($sformatf("%s done r=%0d", tag, r), 32'(done_o), 32'(r >= 28));
      check_eq($sformatf("%s busy r=%0d", tag, r), 32'(busy_o), 32'(r < 28));
    end
  endtask

  task automatic check_reset_values(input string tag);
    check_eq({tag, " rst"}, 32'(rst_o), 32'h0000_000F);
    check_eq({tag, " busy"}, 32'(busy_o), 32'd1);
    check_eq({tag, " done"}, 32'(done_o), 32'd0);
    check_eq({tag, " porStatus"}, 32'(pors_o), 32'd1);
    check_eq({tag, " wdStatus"}, 32'(wds_o), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "time limit");
  end

  initial begin
    rstn = 1'b0;
    ext_rstn = 1'b1;   por_in = 1'b0;   por_clear = 1'b0;   wd_kick = 1'b0;
    ext_rstn1 = 1'b1;  por_in1 = 1'b1;  por_clear1 = 1'b0;  wd_kick1 = 1'b0;
    ext_rstn_w = 1'b1; por_in_w = 1'b1; por_clear_w = 1'b0; wd_kick_w = 1'b0;

    // Power-up: three reset cycles, then two sync edges before the stretch starts
    repeat (3) step();
    check_reset_values("reset");
    rstn = 1'b1;
    step();
    check_eq("sync e1 rst", 32'(rst_o), 32'h0000_000F);
    step();
    check_eq("sync e2 rst", 32'(rst_o), 32'h0000_000F);
    check_release("boot", 28);
    check_eq("boot porStatus", 32'(pors_o), 32'd1);

    // One-cycle extRstn pulse from RUN: reassert after three edges
    ext_rstn = 1'b0;
    step();
    ext_rstn = 1'b1;
    check_eq("ext e1 rst", 32'(rst_o), 32'd0);
    step();
    check_eq("ext e2 rst", 32'(rst_o), 32'd0);
    check_eq("ext e2 done", 32'(done_o), 32'd1);
    step();
    check_eq("ext e3 rst", 32'(rst_o), 32'h0000_000F);
    check_eq("ext e3 done", 32'(done_o), 32'd0);
    check_eq("ext e3 busy", 32'(busy_o), 32'd1);
    check_release("ext", 28);

    // porIn glitch at stretch cycle 10 restarts the stretch
    por_in = 1'b1;
    step();
    por_in = 1'b0;
    check_eq("por enter rst", 32'(rst_o), 32'h0000_000F);
    repeat (10) step();
    check_eq("por c10 rst", 32'(rst_o), 32'h0000_000F);
    por_in = 1'b1;
    step();
    por_in = 1'b0;
    check_eq("por glitch porStatus", 32'(pors_o), 32'd1);
    check_release("por", 28);

    // Sticky porStatus: set wins over clear, clear alone clears
    por_in = 1'b1;
    por_clear = 1'b1;
    step();
    por_in = 1'b0;
    check_eq("por set+clr", 32'(pors_o), 32'd1);
    step();
    check_eq("por clr", 32'(pors_o), 32'd0);
    por_clear = 1'b0;
    step();
    check_eq("por hold0", 32'(pors_o), 32'd0);

    // rstn mid-release wipes the partial release
    repeat (20) step();
    check_eq("mid rel rst", 32'(rst_o), 32'h0000_000C);
    check_eq("mid rel busy", 32'(busy_o), 32'd1);
    rstn = 1'b0;
    step();
    check_reset_values("mid reset");
    rstn = 1'b1;
    step();
    check_eq("rerun e1 rst", 32'(rst_o), 32'h0000_000F);
    step();
    check_eq("rerun e2 rst", 32'(rst_o), 32'h0000_000F);
    check_release("rerun", 28);

    // Single channel, STRETCH=GAP=1: release on the first request-free edge
    check_eq("n1 held rst", 32'(rst1), 32'd1);
    check_eq("n1 held done", 32'(done1), 32'd0);
    por_in1 = 1'b0;
    step();
    check_eq("n1 rel rst", 32'(rst1), 32'd0);
    check_eq("n1 rel done", 32'(done1), 32'd1);
    check_eq("n1 rel busy", 32'(busy1), 32'd0);
    por_in1 = 1'b1;
    step();
    check_eq("n1 reassert rst", 32'(rst1), 32'd1);
    check_eq("n1 reassert done", 32'(done1), 32'd0);
    por_in1 = 1'b0;
    step();
    check_eq("n1 rel2 rst", 32'(rst1), 32'd0);
    check_eq("n1 rel2 done", 32'(done1), 32'd1);

    // Watchdog instance (WDOG_CYCLES=8): kicks every 7 cycles, then none
    por_in_w = 1'b0;
    repeat (28) step();
    check_eq("wd run rst", 32'(rst_w), 32'd0);
    check_eq("wd run done", 32'(done_w), 32'd1);
    for (int i = 0; i < 4; i++) begin
      repeat (6) step();
      wd_kick_w = 1'b1;
      step();
      wd_kick_w = 1'b0;
      check_eq($sformatf("wd kick%0d rst", i), 32'(rst_w), 32'd0);
      check_eq($sformatf("wd kick%0d status", i), 32'(wds_w), 32'd0);
    end
    repeat (7) step();
    check_eq("wd pretrip rst", 32'(rst_w), 32'd0);
    step();
`ifdef RESET_SEQ_WDOG_EN
    check_eq("wd trip rst", 32'(rst_w), 32'h0000_000F);
    check_eq("wd trip status", 32'(wds_w), 32'd1);
    check_eq("wd trip done", 32'(done_w), 32'd0);
`else
    check_eq("wd notrip rst", 32'(rst_w), 32'd0);
    check_eq("wd notrip status", 32'(wds_w), 32'd0);
    check_eq("wd notrip done", 32'(done_w), 32'd1);
`endif
    por_clear_w = 1'b1;
    step();
    por_clear_w = 1'b0;
    check_eq("wd clr status", 32'(wds_w), 32'd0);
    check_eq("wd clr porStatus", 32'(pors_w), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
